// File: rtl/road_pkg.sv
// Shared types and constants for the scrolling road background.
package road_pkg;

  localparam int COORD_W     = 11;
  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;

  typedef enum logic [1:0] {
    LVL0 = 2'd0,
    LVL1 = 2'd1,
    LVL2 = 2'd2,
    LVL3 = 2'd3
  } level_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } flash_state_t;

  typedef struct packed {
    logic [7:0] grass;
    logic [7:0] road;
    logic [7:0] mark;
  } palette_t;

  localparam palette_t PAL_L0 = '{grass: 8'h1C, road: 8'h49, mark: 8'hFF};
  localparam palette_t PAL_L1 = '{grass: 8'hF4, road: 8'h6D, mark: 8'hFC};
  localparam palette_t PAL_L2 = '{grass: 8'hFF, road: 8'h92, mark: 8'h03};
  localparam palette_t PAL_L3 = '{grass: 8'h10, road: 8'h24, mark: 8'hE0};

  function automatic palette_t get_palette(input level_t lvl);
    palette_t p;
    case (lvl)
      LVL0:    p = PAL_L0;
      LVL1:    p = PAL_L1;
      LVL2:    p = PAL_L2;
      LVL3:    p = PAL_L3;
      default: p = PAL_L0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/road_bg_scroller_if.sv
// Pixel-stream bundle: scan position and frame controls in, colour and status out.
interface road_bg_scroller_if;
  import road_pkg::*;

  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               startOfFrame;
  logic [1:0]         levelSel;
  logic [3:0]         speed;
  logic               pause;
  logic [7:0]         BG_RGB;
  logic               boardersDrawReq;
  logic               flashActive;

  modport master (
    output pixelX, pixelY, startOfFrame, levelSel, speed, pause,
    input  BG_RGB, boardersDrawReq, flashActive
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, levelSel, speed, pause,
    output BG_RGB, boardersDrawReq, flashActive
  );
endinterface

// File: rtl/road_bg_scroller_lane_mark_gen.sv
// Combinational marking detector: solid road edge lines plus dashed lane
// dividers gated by the scrolled stripe phase.
module lane_mark_gen
  import road_pkg::*;
#(
  parameter int ROAD_LEFT  = 64,
  parameter int ROAD_RIGHT = 480,
  parameter int NUM_LANES  = 3,
  parameter int MARK_W     = 4,
  parameter int STRIPE_LEN = 32,
  parameter int PH_W       = 6
) (
  input  logic [COORD_W-1:0] i_pixelX,
  input  logic [PH_W-1:0]    i_phase,
  output logic               o_isMark
);

  localparam int LW   = (ROAD_RIGHT - ROAD_LEFT + 1) / NUM_LANES;
  localparam int HALF = MARK_W / 2;

  logic w_edge;
  logic w_lane;
  logic w_stripe_on;

  // Classify the column: inside an edge line, or within HALF of a lane boundary.
  always_comb begin
    int px;
    int dx;
    px     = int'(i_pixelX);
    w_edge = ((px >= ROAD_LEFT) && (px < ROAD_LEFT + MARK_W)) ||
             ((px <= ROAD_RIGHT) && (px > ROAD_RIGHT - MARK_W));
    w_lane = 1'b0;
    for (int k = 1; k < NUM_LANES; k++) begin
      dx = px - (ROAD_LEFT + k * LW);
      if ((dx > -HALF) && (dx < HALF)) begin
        w_lane = 1'b1;
      end
    end
  end

  assign w_stripe_on = (int'(i_phase) < STRIPE_LEN);
  assign o_isMark    = w_edge || (w_lane && w_stripe_on);

endmodule

// File: rtl/road_bg_scroller.sv
// Road background generator: grass/road/marking colouring with vertical
// stripe scrolling, per-level palettes and a blinking level-change flash.
module road_bg_scroller
  import road_pkg::*;
#(
  parameter int ROAD_LEFT     = 64,
  parameter int ROAD_RIGHT    = 480,
  parameter int FRAME_W       = FRAME_W_DEF,
  parameter int FRAME_H       = FRAME_H_DEF,
  parameter int NUM_LANES     = 3,
  parameter int MARK_W        = 4,
  parameter int STRIPE_PERIOD = 64,
  parameter int STRIPE_LEN    = 32,
  parameter int FLASH_FRAMES  = 30
) (
  input  logic               clk,
  input  logic               resetN,
  road_bg_scroller_if.slave  bus
);

  localparam int PH_W  = (STRIPE_PERIOD > 1) ? $clog2(STRIPE_PERIOD) : 1;
  localparam int CNT_W = ($clog2(FLASH_FRAMES) < 3) ? 3 : $clog2(FLASH_FRAMES);

  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [COORD_W-1:0] FW       = COORD_W'(FRAME_W);
  localparam logic [COORD_W-1:0] FH       = COORD_W'(FRAME_H);
  localparam logic [COORD_W-1:0] RL       = COORD_W'(ROAD_LEFT);
  localparam logic [COORD_W-1:0] RR       = COORD_W'(ROAD_RIGHT);

  flash_state_t     r_state;
  flash_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  level_t           r_level;
  level_t           w_level_nxt;
  level_t           w_level_req;
  logic [PH_W-1:0]  r_scroll;

  logic [PH_W-1:0]  w_phase;
  logic             w_isMark;
  logic             w_invert;
  palette_t         w_pal;
  logic [7:0]       w_bg_p0;
  logic             w_req_p0;
  logic [7:0]       r_bg_p1;
  logic             r_req_p1;

  assign w_level_req = level_t'(bus.levelSel);

  // Stripe offset advances by speed once per frame unless paused.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_scroll <= '0;
    end else if (bus.startOfFrame && !bus.pause) begin
      r_scroll <= r_scroll + PH_W'(bus.speed);
    end
  end

  // Flash FSM, frame counter and active level registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= LVL0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next-state logic: all changes happen only at the start of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    if (bus.startOfFrame) begin
      w_level_nxt = w_level_req;
      case (r_state)
        ST_IDLE: begin
          if (w_level_req != r_level) begin
            w_state_nxt = ST_FLASH;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        ST_FLASH: begin
          if (w_level_req != r_level) begin
            w_cnt_nxt = CNT_LOAD;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_invert = (r_state == ST_FLASH) && r_cnt[2];
  assign w_phase  = PH_W'(bus.pixelY) - r_scroll;

  lane_mark_gen #(
    .ROAD_LEFT  (ROAD_LEFT),
    .ROAD_RIGHT (ROAD_RIGHT),
    .NUM_LANES  (NUM_LANES),
    .MARK_W     (MARK_W),
    .STRIPE_LEN (STRIPE_LEN),
    .PH_W       (PH_W)
  ) u_lane_mark_gen (
    .i_pixelX (bus.pixelX),
    .i_phase  (w_phase),
    .o_isMark (w_isMark)
  );

  // Pixel colour and collision flag for the current scan position.
  always_comb begin
    w_pal    = get_palette(r_level);
    w_bg_p0  = 8'h00;
    w_req_p0 = 1'b0;
    if ((bus.pixelX >= FW) || (bus.pixelY >= FH)) begin
      w_bg_p0  = 8'h00;
      w_req_p0 = 1'b0;
    end else if ((bus.pixelX < RL) || (bus.pixelX > RR)) begin
      w_bg_p0  = w_invert ? ~w_pal.grass : w_pal.grass;
      w_req_p0 = 1'b1;
    end else if (w_isMark) begin
      w_bg_p0  = w_pal.mark;
    end else begin
      w_bg_p0  = w_invert ? ~w_pal.road : w_pal.road;
    end
  end

  // p0 -> p1: register the colour one cycle after the pixel position.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_bg_p1  <= 8'h00;
      r_req_p1 <= 1'b0;
    end else begin
      r_bg_p1  <= w_bg_p0;
      r_req_p1 <= w_req_p0;
    end
  end

  assign bus.BG_RGB          = r_bg_p1;
  assign bus.boardersDrawReq = r_req_p1;
  assign bus.flashActive     = (r_state == ST_FLASH);

endmodule
